wb_sram_responder: RTL and testbench
====================================

Name: wb_sram_responder

Overview:
- Wishbone B4 classic single-outstanding responder backing a word-organised SRAM array.
- Terminates transactions issued by the data-memory initiator in the memory pipeline stage.
- Drop-in data RAM with configurable wait states, so the stage's stall path is exercised under realistic latency.
- Handles byte-lane writes, address decode against a base/size window, and bus-cycle abort.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, >= 16.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_STATES, 1, extra cycles between accept and ack; 0..15.

Ports:
- iClk  input  1  clock; all state on rising edge.
- iRst  input  1  reset, asynchronous, active-high.
- iCyc  input  1  bus cycle active.
- iStb  input  1  strobe, request valid.
- iWe  input  1  1 = write, 0 = read.
- iAddr  input  32  byte address.
- iData  input  32  write data.
- iSel  input  4  byte-lane enables; bit n covers bits [8n+7:8n].
- oData  output  32  read data; valid only while oAck = 1.
- oAck  output  1  normal termination, single-cycle pulse.
- oErr  output  1  error termination, single-cycle pulse.
- oStall  output  1  responder busy; request not accepted while high.

Behaviour:
- Reset:
  - Asynchronous active-high on iRst.
  - oData = 0, oAck = 0, oErr = 0, oStall = 0, FSM = IDLE, wait counter = 0.
  - Array contents are not reset.
- Accept: iCyc & iStb & ~oStall in IDLE. Latch iWe, iAddr, iData, iSel. oStall goes high on the following cycle.
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> WAIT on accept when WAIT_STATES > 0, with counter loaded to WAIT_STATES-1.
  - IDLE -> RESP on accept when WAIT_STATES = 0.
  - WAIT decrements the counter and moves to RESP when it reaches 0.
  - RESP drives oAck or oErr high for exactly one cycle, then returns to IDLE with oStall low.
- Latency: termination appears WAIT_STATES+1 cycles after the accept edge. With WAIT_STATES = 0, ack is on the cycle after accept.
- Back-to-back requests: the next accept may occur on the cycle after RESP. Throughput is one transfer per WAIT_STATES+2 cycles.
- Decode:
  - Word index = (iAddr - BASE_ADDR) >> 2.
  - In range when BASE_ADDR <= iAddr < BASE_ADDR + DEPTH_WORDS*4.
  - Index uses $clog2(DEPTH_WORDS) bits; the subtraction is 32-bit unsigned.
- Write:
  - Committed to the array in the RESP cycle, only lanes with iSel set; other lanes keep their prior value.
  - iSel = 0 -> ack, no change.
- Read:
  - oData loaded from the array in the cycle entering RESP, with all 4 bytes returned regardless of iSel.
  - oData returns to 0 after RESP.
- Error conditions (see Optional Feature): out-of-range address, or iAddr[1:0] != 0. An errored write never modifies the array.
- Abort:
  - iCyc deasserted while in WAIT or RESP -> immediate return to IDLE; no ack/err, no write, oStall low on the next cycle.
  - iStb low while iCyc high does not abort.
- Reset mid-transfer: no array write, no termination pulse; outputs take reset values asynchronously.
- Never assert oAck and oErr together. Never terminate without a prior accept.

Optional Feature:
- Macro WB_RESP_ERR_EN.
- Defined: out-of-range or misaligned accesses terminate with oErr (oAck = 0, oData = 0, no write).
- Undefined:
  - oErr tied 0.
  - Address bits [1:0] ignored.
  - Index wraps modulo DEPTH_WORDS, and every access acks.

Test Plan:
- Write/read, WAIT_STATES=1: write 32'hDEADBEEF, iSel=4'hF to BASE_ADDR+8 -> oAck 2 cycles after accept. Read the same address -> oAck with oData=32'hDEADBEEF.
- Byte lanes: preload 32'h11223344, write 32'hAABBCCDD with iSel=4'b0101 -> read returns 32'h11BB33DD.
- Latency sweep: WAIT_STATES = 0, 3, 15 -> ack at exactly 1, 4, 16 cycles after accept. oStall is high in every intervening cycle, and a strobe held during stall is accepted the cycle after ack.
- Abort: accept write to BASE_ADDR+4 with WAIT_STATES=3, drop iCyc one cycle later -> no oAck/oErr, idle next cycle. A subsequent read returns the old value.
- Error path (WB_RESP_ERR_EN defined): write to BASE_ADDR+DEPTH_WORDS*4 -> oErr pulse, no ack. Read of BASE_ADDR+2 -> oErr. Without the macro, the same write acks and lands at index 0.
- Reset mid-op: assert iRst in WAIT of a write -> outputs 0 within the same cycle, no write occurs. After release, IDLE accepts immediately.

Source files
------------

// File: rtl/wb_sram_responder_if.sv
// Wishbone B4 classic bus bundle between the data-memory initiator and the SRAM responder.
// Signal names follow the responder's view: i* are driven by the initiator, o* by the responder.
interface wb_sram_responder_if;
    logic        iCyc;
    logic        iStb;
    logic        iWe;
    logic [31:0] iAddr;
    logic [31:0] iData;
    logic [3:0]  iSel;
    logic [31:0] oData;
    logic        oAck;
    logic        oErr;
    logic        oStall;

    modport master (
        output iCyc, iStb, iWe, iAddr, iData, iSel,
        input  oData, oAck, oErr, oStall
    );

    modport slave (
        input  iCyc, iStb, iWe, iAddr, iData, iSel,
        output oData, oAck, oErr, oStall
    );
endinterface

// File: rtl/wb_sram_responder.sv
// Single-outstanding Wishbone classic responder in front of a word-organised SRAM with wait states.
// Define WB_RESP_ERR_EN to terminate out-of-window or misaligned accesses with oErr instead of wrapping.
module wb_sram_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic                iClk,
    input  logic                iRst,
    wb_sram_responder_if.slave  wb
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // state  | meaning
    // S_IDLE | ready, oStall low, accepts a strobe
    // S_WAIT | request latched, counting down wait states
    // S_RESP | termination cycle: oAck/oErr pulse, write commit
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdat_q, wdat_d;
    logic [3:0]      sel_q, sel_d;
    logic            err_q, err_d;
    logic [31:0]     rdat_q, rdat_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic [31:0]     offset;
    logic [AW-1:0]   bus_idx;
    logic            bus_err;
    logic [AW-1:0]   rd_idx;
    logic            rd_we;
    logic            rd_err;

    assign accept  = (state_q == S_IDLE) && wb.iCyc && wb.iStb;
    assign offset  = wb.iAddr - BASE_ADDR;
    assign bus_idx = offset[AW+1:2];

`ifdef WB_RESP_ERR_EN
    assign bus_err = (offset >= 32'(DEPTH_WORDS * 4)) || (wb.iAddr[1:0] != 2'b00);
`else
    // Upper offset bits and the byte offset are don't-care: the index wraps.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdat_q  <= 32'd0;
            sel_q   <= 4'd0;
            err_q   <= 1'b0;
            rdat_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!wb.iCyc) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture and read-data load; the read uses the live bus fields when
    // entering RESP straight from IDLE (zero wait states).
    always_comb begin
        we_d   = we_q;
        idx_d  = idx_q;
        wdat_d = wdat_q;
        sel_d  = sel_q;
        err_d  = err_q;
        if (accept) begin
            we_d   = wb.iWe;
            idx_d  = bus_idx;
            wdat_d = wb.iData;
            sel_d  = wb.iSel;
            err_d  = bus_err;
        end

        rd_idx = (state_q == S_IDLE) ? bus_idx : idx_q;
        rd_we  = (state_q == S_IDLE) ? wb.iWe  : we_q;
        rd_err = (state_q == S_IDLE) ? bus_err : err_q;

        rdat_d = 32'd0;
        if ((state_d == S_RESP) && (state_q != S_RESP) && !rd_we && !rd_err) begin
            rdat_d = mem[rd_idx];
        end
    end

    always_ff @(posedge iClk) begin
        if ((state_q == S_RESP) && wb.iCyc && we_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    // iCyc gates the termination so an abort in RESP suppresses the pulse immediately.
    always_comb begin
        wb.oAck   = (state_q == S_RESP) && wb.iCyc && !err_q;
        wb.oErr   = (state_q == S_RESP) && wb.iCyc && err_q;
        wb.oStall = (state_q != S_IDLE);
        wb.oData  = rdat_q;
    end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Bench for wb_sram_responder: four instances (wait states 1, 0, 3, 15) against an array reference model.
module tb_wb_sram_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          NDUT  = 4;

    logic        clk;
    logic        rst   [NDUT];
    logic        cyc   [NDUT];
    logic        stb   [NDUT];
    logic        we    [NDUT];
    logic [31:0] addr  [NDUT];
    logic [31:0] wdat  [NDUT];
    logic [3:0]  sel   [NDUT];
    logic [31:0] rdat  [NDUT];
    logic        ack   [NDUT];
    logic        err   [NDUT];
    logic        stall [NDUT];

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] ref_mem [NDUT][DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15;
        wb_sram_responder_if bus ();
        assign bus.iCyc  = cyc[g];
        assign bus.iStb  = stb[g];
        assign bus.iWe   = we[g];
        assign bus.iAddr = addr[g];
        assign bus.iData = wdat[g];
        assign bus.iSel  = sel[g];
        assign rdat[g]   = bus.oData;
        assign ack[g]    = bus.oAck;
        assign err[g]    = bus.oErr;
        assign stall[g]  = bus.oStall;
        wb_sram_responder #(
            .DEPTH_WORDS (DEPTH),
            .BASE_ADDR   (BASE),
            .WAIT_STATES (WS)
        ) dut (
            .iClk (clk),
            .iRst (rst[g]),
            .wb   (bus.slave)
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : (k == 2) ? 3 : 15;
    endfunction

    function automatic bit model_err(input logic [31:0] a);
`ifdef WB_RESP_ERR_EN
        return ((a - BASE) >= 32'(DEPTH * 4)) || (a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) / 4;
        return int'(off % DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus transaction; returns termination flags, data and cycles from accept to termination.
    task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic g_ack, output logic g_err,
                       output logic [31:0] g_dat, output int lat);
        bit done;
        bit stall_bad;
        done = 0; stall_bad = 0; g_ack = 0; g_err = 0; g_dat = 32'd0; lat = 0;
        @(negedge clk);
        chk($sformatf("dut%0d stall_before_accept", k), 32'(stall[k]), 32'd0);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; wdat[k] = d; sel[k] = s;
        @(posedge clk);
        #1 stb[k] = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack[k] || err[k]) begin
                done  = 1;
                g_ack = ack[k];
                g_err = err[k];
                g_dat = rdat[k];
            end else if (stall[k] !== 1'b1) begin
                stall_bad = 1;
            end
        end
        chk($sformatf("dut%0d stall_while_busy", k), 32'(stall_bad), 32'd0);
        @(posedge clk);
        #1 cyc[k] = 1'b0;
    endtask

    // Transaction checked against the reference model, which is then updated.
    task automatic run(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic g_ack, output logic g_err,
                       output logic [31:0] g_dat);
        bit          e_err;
        int          idx;
        int          lat;
        logic [31:0] e_dat;
        e_err = model_err(a);
        idx   = model_idx(a);
        e_dat = (!w && !e_err) ? ref_mem[k][idx] : 32'd0;
        txn(k, w, a, d, s, g_ack, g_err, g_dat, lat);
        chk($sformatf("dut%0d ack a=%h we=%0d", k, a, w), 32'(g_ack), 32'(!e_err));
        chk($sformatf("dut%0d err a=%h we=%0d", k, a, w), 32'(g_err), 32'(e_err));
        chk($sformatf("dut%0d latency", k), lat, ws_of(k) + 1);
        if (!w) chk($sformatf("dut%0d rdata a=%h", k, a), g_dat, e_dat);
        if (w && !e_err) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[k][idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        e_ack;
        logic        e_err;
        logic [31:0] e_dat;
        logic        chk_dat;
    } vec_t;

    vec_t vt [12];

    task automatic setv(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic ea, input logic ee,
                        input logic [31:0] ed, input logic cd);
        vt[i] = '{w: w, a: a, d: d, s: s, e_ack: ea, e_err: ee, e_dat: ed, chk_dat: cd};
    endtask

    // Two reads with the strobe held through the stall; second accept must follow the first ack.
    task automatic b2b(input int k, input logic [31:0] a0, input logic [31:0] a1);
        int          t;
        bit          seen;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] d0;
        logic [31:0] d1;
        e0 = ref_mem[k][model_idx(a0)];
        e1 = ref_mem[k][model_idx(a1)];
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b0; addr[k] = a0; sel[k] = 4'hF;
        @(posedge clk);
        #1 addr[k] = a1;
        t = 0; seen = 0; d0 = 32'd0;
        while (!seen && t < 40) begin
            @(negedge clk); t++;
            if (ack[k]) begin seen = 1; d0 = rdat[k]; end
        end
        chk($sformatf("dut%0d b2b first_lat", k), t, ws_of(k) + 1);
        chk($sformatf("dut%0d b2b first_data", k), d0, e0);
        t = 0; seen = 0; d1 = 32'd0;
        while (!seen && t < 40) begin
            @(negedge clk); t++;
            if (ack[k]) begin seen = 1; d1 = rdat[k]; stb[k] = 1'b0; end
        end
        stb[k] = 1'b0;
        chk($sformatf("dut%0d b2b ack_gap", k), t, ws_of(k) + 2);
        chk($sformatf("dut%0d b2b second_data", k), d1, e1);
        @(posedge clk);
        #1 cyc[k] = 1'b0;
    endtask

    initial begin
        logic        g_ack;
        logic        g_err;
        logic [31:0] g_dat;
        logic [31:0] old;
        bit          term;

        for (int k = 0; k < NDUT; k++) begin
            rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            addr[k] = 32'd0; wdat[k] = 32'd0; sel[k] = 4'd0;
        end
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("dut%0d reset stall", k), 32'(stall[k]), 32'd0);
            chk($sformatf("dut%0d reset ack", k), 32'(ack[k]), 32'd0);
            chk($sformatf("dut%0d reset err", k), 32'(err[k]), 32'd0);
            chk($sformatf("dut%0d reset data", k), rdat[k], 32'd0);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;

        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < DEPTH; i++)
                run(k, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, g_ack, g_err, g_dat);

        setv(0, 1, BASE + 0,  32'hCAFEF00D, 4'hF, 1, 0, 32'h0, 0);
        setv(1, 1, BASE + 8,  32'hDEADBEEF, 4'hF, 1, 0, 32'h0, 0);
        setv(2, 0, BASE + 8,  32'h0,        4'hF, 1, 0, 32'hDEADBEEF, 1);
        setv(3, 1, BASE + 12, 32'h11223344, 4'hF, 1, 0, 32'h0, 0);
        setv(4, 1, BASE + 12, 32'hAABBCCDD, 4'b0101, 1, 0, 32'h0, 0);
        setv(5, 0, BASE + 12, 32'h0,        4'h0, 1, 0, 32'h11BB33DD, 1);
        setv(6, 1, BASE + 12, 32'hFFFFFFFF, 4'h0, 1, 0, 32'h0, 0);
        setv(7, 0, BASE + 12, 32'h0,        4'hF, 1, 0, 32'h11BB33DD, 1);
`ifdef WB_RESP_ERR_EN
        setv(8,  1, BASE + 64, 32'h12345678, 4'hF, 0, 1, 32'h0, 0);
        setv(9,  0, BASE + 0,  32'h0,        4'hF, 1, 0, 32'hCAFEF00D, 1);
        setv(10, 0, BASE + 2,  32'h0,        4'hF, 0, 1, 32'h0, 1);
        setv(11, 0, BASE - 4,  32'h0,        4'hF, 0, 1, 32'h0, 1);
`else
        setv(8,  1, BASE + 64, 32'h12345678, 4'hF, 1, 0, 32'h0, 0);
        setv(9,  0, BASE + 0,  32'h0,        4'hF, 1, 0, 32'h12345678, 1);
        setv(10, 0, BASE + 2,  32'h0,        4'hF, 1, 0, 32'h12345678, 1);
        setv(11, 0, BASE - 4,  32'h0,        4'hF, 1, 0, 32'h0, 0);
`endif
        for (int i = 0; i < 12; i++) begin
            run(0, vt[i].w, vt[i].a, vt[i].d, vt[i].s, g_ack, g_err, g_dat);
            chk($sformatf("vec%0d ack", i), 32'(g_ack), 32'(vt[i].e_ack));
            chk($sformatf("vec%0d err", i), 32'(g_err), 32'(vt[i].e_err));
            if (vt[i].chk_dat) chk($sformatf("vec%0d data", i), g_dat, vt[i].e_dat);
        end

        b2b(1, BASE + 4, BASE + 40);
        b2b(2, BASE + 16, BASE + 60);

        // Abort: drop iCyc one cycle after accepting a write on the 3-wait-state instance.
        old = ref_mem[2][1];
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = BASE + 4; wdat[2] = ~old; sel[2] = 4'hF;
        @(posedge clk);
        #1 stb[2] = 1'b0;
        @(posedge clk);
        #1 cyc[2] = 1'b0;
        term = 0;
        @(negedge clk); term |= (ack[2] | err[2]);
        @(negedge clk); term |= (ack[2] | err[2]);
        chk("abort idle_next_cycle", 32'(stall[2]), 32'd0);
        repeat (4) begin @(negedge clk); term |= (ack[2] | err[2]); end
        chk("abort no_termination", 32'(term), 32'd0);
        run(2, 1'b0, BASE + 4, 32'd0, 4'hF, g_ack, g_err, g_dat);
        chk("abort old_value_kept", g_dat, old);

        // Reset mid-write on the 15-wait-state instance.
        old = ref_mem[3][5];
        @(negedge clk);
        cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b1; addr[3] = BASE + 20; wdat[3] = ~old; sel[3] = 4'hF;
        @(posedge clk);
        #1 stb[3] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst busy_before", 32'(stall[3]), 32'd1);
        rst[3] = 1'b1;
        #1;
        chk("rst stall", 32'(stall[3]), 32'd0);
        chk("rst ack", 32'(ack[3]), 32'd0);
        chk("rst err", 32'(err[3]), 32'd0);
        chk("rst data", rdat[3], 32'd0);
        @(negedge clk);
        rst[3] = 1'b0; cyc[3] = 1'b0;
        run(3, 1'b0, BASE + 20, 32'd0, 4'hF, g_ack, g_err, g_dat);
        chk("rst no_write", g_dat, old);

        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 30; n++) begin
                int          r;
                logic [31:0] a;
                r = int'($urandom % 10);
                if (r < 7)       a = BASE + 32'(4 * ($urandom % DEPTH));
                else if (r == 7) a = BASE + 32'(4 * DEPTH) + 32'(4 * ($urandom % 4));
                else if (r == 8) a = BASE - 32'(4 * (1 + $urandom % 4));
                else             a = BASE + 32'($urandom % (4 * DEPTH));
                run(k, 1'($urandom % 2), a, $urandom, 4'($urandom % 16), g_ack, g_err, g_dat);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
